transpose_seq_ctrl: RTL and testbench

Sequencer that performs an in-place-free DIM x DIM matrix transpose between a synchronous-read source memory (memref_rd style) and a write-only destination memory (memref_wr style). It generates row-major read addresses and transposed write addresses, and tracks read latency with a valid/address delay line. It also provides start/busy/done handshaking. It is the hand-written RTL controller placed alongside the HIR and HLS transpose kernels in the transpose testbench, and it uses the same memory port wiring.

---
 rtl/transpose_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_transpose_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_seq_ctrl.sv
// transpose_seq_ctrl
//   Sequencer for a DIM x DIM matrix transpose from a synchronous-read source
//   memory into a write-only destination memory. Reads are issued in
//   row-major order; each read carries its transposed destination address
//   through an RD_LAT-deep tag/valid delay line so the write lines up with
//   the returning read data.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   tstart   : start request, honoured only in IDLE
//   hold     : pauses read issue in RUN; in-flight writes still complete
//   busy     : high from the first RUN cycle through the done cycle
//   done     : one-cycle pulse after the final write has been issued
//   rd_en    : source read enable
//   rd_addr  : source read address, i*DIM + j
//   rd_data  : source read data, valid RD_LAT cycles after rd_en
//   wr_en    : destination write enable (registered)
//   wr_addr  : destination write address, j*DIM + i (registered)
//   wr_data  : destination write data (registered)
module transpose_seq_ctrl #(
   parameter int DIM    = 16,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tstart,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data
);

   localparam int IDX_W = ADDR_W / 2;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
   localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(DIM * DIM - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t state, next_state;

   logic [IDX_W-1:0] i, j;
   logic [CNT_W-1:0] wcount;
   logic             issue;

   // Delay line: index 0 is loaded with the read just issued; index
   // RD_LAT-1 lines up with the cycle its rd_data is valid.
   logic [RD_LAT-1:0]             vld_p;
   logic [RD_LAT-1:0][ADDR_W-1:0] tag_p;

   // Counters are DIM-wide powers of two, so {i,j} is i*DIM+j and {j,i}
   // is the transposed address with no multiplier.
   assign rd_addr = {i, j};
   assign rd_en   = issue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      issue      = 1'b0;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (tstart) next_state = S_RUN;
         end
         S_RUN: begin
            // hold gates issue in the same cycle so a held cycle never reads
            issue = ~hold;
            if (issue && (i == LAST_IDX) && (j == LAST_IDX)) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            // the write now being presented is the last one
            if (wr_en && (wcount == LAST_WR)) next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i       <= '0;
         j       <= '0;
         wcount  <= '0;
         vld_p   <= '0;
         tag_p   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         if (state == S_IDLE && tstart) begin
            i      <= '0;
            j      <= '0;
            wcount <= '0;
         end else begin
            if (issue) begin
               j <= j + 1'b1;
               if (j == LAST_IDX) i <= i + 1'b1;
            end
            if (wr_en) wcount <= wcount + 1'b1;
         end

         vld_p[0] <= issue;
         tag_p[0] <= {j, i};
         for (int k = 1; k < RD_LAT; k++) begin
            vld_p[k] <= vld_p[k-1];
            tag_p[k] <= tag_p[k-1];
         end

         // rd_data is captured only while a valid tag leaves the line
         wr_en <= vld_p[RD_LAT-1];
         if (vld_p[RD_LAT-1]) begin
            wr_addr <= tag_p[RD_LAT-1];
            wr_data <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_transpose_seq_ctrl.sv
// tb_transpose_seq_ctrl
//   Directed bench for transpose_seq_ctrl. Three instances cover
//   DIM=16/RD_LAT=1, DIM=16/RD_LAT=3 and DIM=4/ADDR_W=4. Cycle 0 of every run
//   is the cycle in which tstart is driven high.
module tb_transpose_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance A: DIM=16, RD_LAT=1
   logic        tstart_a = 1'b0, hold_a = 1'b0;
   logic        busy_a, done_a, rd_en_a, wr_en_a;
   logic [7:0]  rd_addr_a, wr_addr_a;
   logic [31:0] rd_data_a, wr_data_a;
   // instance B: DIM=16, RD_LAT=3
   logic        tstart_b = 1'b0;
   logic        busy_b, done_b, rd_en_b, wr_en_b;
   logic [7:0]  rd_addr_b, wr_addr_b;
   logic [31:0] rd_data_b, wr_data_b;
   logic [31:0] q1_b, q2_b;
   // instance C: DIM=4, ADDR_W=4, RD_LAT=1
   logic        tstart_c = 1'b0;
   logic        busy_c, done_c, rd_en_c, wr_en_c;
   logic [3:0]  rd_addr_c, wr_addr_c;
   logic [31:0] rd_data_c, wr_data_c;

   transpose_seq_ctrl u_a (
      .clk(clk), .rst(rst), .tstart(tstart_a), .hold(hold_a), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

   transpose_seq_ctrl #(.RD_LAT(3)) u_b (
      .clk(clk), .rst(rst), .tstart(tstart_b), .hold(1'b0), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

   transpose_seq_ctrl #(.DIM(4), .ADDR_W(4)) u_c (
      .clk(clk), .rst(rst), .tstart(tstart_c), .hold(1'b0), .busy(busy_c), .done(done_c),
      .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
      .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c));

   // Source memories: Ai[k]=k for A/B, Ai[k]=k+100 for C. Non-read cycles
   // return a poison word so mistimed captures show up in Co.
   always @(posedge clk) begin
      rd_data_a <= rd_en_a ? 32'(rd_addr_a) : 32'hDEAD_BEEF;
      q1_b      <= rd_en_b ? 32'(rd_addr_b) : 32'hDEAD_BEEF;
      q2_b      <= q1_b;
      rd_data_b <= q2_b;
      rd_data_c <= rd_en_c ? 32'(rd_addr_c) + 32'd100 : 32'hDEAD_BEEF;
   end

   // observation mux for the instance under test
   int cur = 0;
   logic m_rd_en, m_wr_en, m_busy, m_done;
   int   m_rd_addr, m_wr_addr, m_wr_data;
   always_comb begin
      m_rd_en = rd_en_a; m_wr_en = wr_en_a; m_busy = busy_a; m_done = done_a;
      m_rd_addr = int'(rd_addr_a); m_wr_addr = int'(wr_addr_a); m_wr_data = int'(wr_data_a);
      if (cur == 1) begin
         m_rd_en = rd_en_b; m_wr_en = wr_en_b; m_busy = busy_b; m_done = done_b;
         m_rd_addr = int'(rd_addr_b); m_wr_addr = int'(wr_addr_b); m_wr_data = int'(wr_data_b);
      end else if (cur == 2) begin
         m_rd_en = rd_en_c; m_wr_en = wr_en_c; m_busy = busy_c; m_done = done_c;
         m_rd_addr = int'(rd_addr_c); m_wr_addr = int'(wr_addr_c); m_wr_data = int'(wr_data_c);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // per-run observations
   int n_rd, n_wr, n_done, first_wr, last_wr, done_cyc, busy_first, busy_last;
   int hold_rd, post_rst_wr, max_rd, dup;
   int co [256];
   bit wseen [256];

   task automatic run(input int sel, input int ncyc, input int hlo, input int hhi,
                      input int ex1, input int ex2, input int rcyc);
      bit st;
      cur = sel;
      n_rd = 0; n_wr = 0; n_done = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
      busy_first = -1; busy_last = -1; hold_rd = 0; post_rst_wr = 0; max_rd = 0; dup = 0;
      for (int k = 0; k < 256; k++) begin co[k] = -1; wseen[k] = 1'b0; end
      for (int c = 0; c <= ncyc; c++) begin
         st = (c == 0) || (c == ex1) || (c == ex2);
         tstart_a = (sel == 0) && st;
         tstart_b = (sel == 1) && st;
         tstart_c = (sel == 2) && st;
         hold_a   = (sel == 0) && (c >= hlo) && (c <= hhi);
         if (c == rcyc + 1) rst = 1'b0;
         if (c == rcyc) begin
            #2;
            chk("pre_rst_rd_en", int'(m_rd_en), 1);
            rst = 1'b1;
            #1;
            chk("rst_rd_en", int'(m_rd_en), 0);
            chk("rst_wr_en", int'(m_wr_en), 0);
            chk("rst_busy",  int'(m_busy), 0);
            chk("rst_done",  int'(m_done), 0);
         end
         @(negedge clk);
         if (m_rd_en) begin
            n_rd++;
            if (m_rd_addr > max_rd) max_rd = m_rd_addr;
            if (c >= hlo && c <= hhi) hold_rd++;
         end
         if (m_wr_en) begin
            n_wr++;
            if (first_wr < 0) first_wr = c;
            last_wr = c;
            if (wseen[m_wr_addr]) dup++;
            wseen[m_wr_addr] = 1'b1;
            co[m_wr_addr] = m_wr_data;
            if (rcyc >= 0 && c > rcyc) post_rst_wr++;
         end
         if (m_done) begin n_done++; done_cyc = c; end
         if (m_busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         @(posedge clk);
         #1;
      end
      tstart_a = 1'b0; tstart_b = 1'b0; tstart_c = 1'b0; hold_a = 1'b0;
   endtask

   function automatic int co_errors(input int d, input int off);
      int bad = 0;
      for (int r = 0; r < d; r++)
         for (int c = 0; c < d; c++)
            if (co[r*d + c] != c*d + r + off) bad++;
      return bad;
   endfunction

   initial begin
      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_rd_en",   int'(rd_en_a), 0);
      chk("reset_wr_en",   int'(wr_en_a), 0);
      chk("reset_busy",    int'(busy_a), 0);
      chk("reset_done",    int'(done_a), 0);
      chk("reset_rd_addr", int'(rd_addr_a), 0);
      chk("reset_wr_data", int'(wr_data_a), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: plain transfer
      run(0, 262, 1, 0, -1, -1, -1);
      chk("t1_n_rd", n_rd, 256);
      chk("t1_n_wr", n_wr, 256);
      chk("t1_first_wr", first_wr, 3);
      chk("t1_last_wr", last_wr, 258);
      chk("t1_done_cyc", done_cyc, 259);
      chk("t1_n_done", n_done, 1);
      chk("t1_busy_first", busy_first, 1);
      chk("t1_busy_last", busy_last, 259);
      chk("t1_rd_max", max_rd, 255);
      chk("t1_dup", dup, 0);
      chk("t1_co1", co[1], 16);
      chk("t1_co16", co[16], 1);
      chk("t1_co17", co[17], 17);
      chk("t1_co255", co[255], 255);
      chk("t1_co_all", co_errors(16, 0), 0);

      // 2: hold over cycles 10..19
      run(0, 272, 10, 19, -1, -1, -1);
      chk("t2_hold_rd", hold_rd, 0);
      chk("t2_n_rd", n_rd, 256);
      chk("t2_n_wr", n_wr, 256);
      chk("t2_last_wr", last_wr, 268);
      chk("t2_done_cyc", done_cyc, 269);
      chk("t2_co_all", co_errors(16, 0), 0);

      // 3: stray tstart in RUN and in DONE, then back-to-back restart at 260
      run(0, 259, 1, 0, 100, 259, -1);
      chk("t3_n_wr", n_wr, 256);
      chk("t3_n_done", n_done, 1);
      chk("t3_done_cyc", done_cyc, 259);
      run(0, 262, 1, 0, -1, -1, -1);
      chk("t3b_busy_first", busy_first, 1);
      chk("t3b_n_wr", n_wr, 256);
      chk("t3b_done_cyc", done_cyc, 259);
      chk("t3b_co_all", co_errors(16, 0), 0);

      // 4: asynchronous reset mid-transfer, then a fresh transfer
      run(0, 120, 1, 0, -1, -1, 50);
      chk("t4_post_rst_wr", post_rst_wr, 0);
      chk("t4_n_done", n_done, 0);
      chk("t4_busy_last", busy_last, 49);
      run(0, 262, 1, 0, -1, -1, -1);
      chk("t4b_n_wr", n_wr, 256);
      chk("t4b_done_cyc", done_cyc, 259);
      chk("t4b_co_all", co_errors(16, 0), 0);

      // 5: RD_LAT=3
      run(1, 264, 1, 0, -1, -1, -1);
      chk("t5_first_wr", first_wr, 5);
      chk("t5_n_wr", n_wr, 256);
      chk("t5_done_cyc", done_cyc, 261);
      chk("t5_dup", dup, 0);
      chk("t5_co_all", co_errors(16, 0), 0);

      // 6: DIM=4, data offset 100
      run(2, 24, 1, 0, -1, -1, -1);
      chk("t6_n_rd", n_rd, 16);
      chk("t6_n_wr", n_wr, 16);
      chk("t6_done_cyc", done_cyc, 19);
      chk("t6_rd_max", max_rd, 15);
      chk("t6_co1", co[1], 104);
      chk("t6_co4", co[4], 101);
      chk("t6_co15", co[15], 115);
      chk("t6_co_all", co_errors(4, 100), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
